fixed_to_float: RTL

Sequential converter from the unsigned Q8.23 fixed-point result produced by the fast-inverse-square-root core (31-bit `fixed_out`) back to an IEEE-754 single-precision float. It sits directly downstream of the FISR core, taking its `fixed_out`/`ready_out` pair on `fixed_in`/`start`. It normalises by iterative left shift (one bit per cycle), rounds to nearest-even and packs sign/exponent/mantissa. Start/ready handshake matches the rest of the FISR datapath.

---
 rtl/fisr_pkg.sv | 8 +
 rtl/rne_round_pack.sv | 14 +
 rtl/fixed_to_float.sv | 86 ++++++++
 3 files changed

// File: rtl/fisr_pkg.sv
// fisr_pkg: constants and types shared by the fast-inverse-square-root datapath.
package fisr_pkg;
    localparam int          FRAC_BITS   = 23;
    localparam int          FLOAT_BIAS  = 127;
    localparam logic [31:0] MAGIC_CONST = 32'h5f3759df;
    localparam logic [30:0] THREE_HALFS = 31'h0C00000;
    typedef enum logic [1:0] {F2X_IDLE, F2X_NORM, F2X_ROUND, F2X_PACK} f2x_state_t;
endpackage

// File: rtl/rne_round_pack.sv
// rne_round_pack: round a normalised mantissa to nearest-even and pack a positive single float.
module rne_round_pack (
    input  logic [29:0] mant,
    input  logic [7:0]  exp,
    input  logic        zero,
    output logic [31:0] packed_o
);
    logic        up;
    logic [23:0] sum;
    assign up       = mant[6] & ((|mant[5:0]) | mant[7]);
    assign sum      = {1'b0, mant[29:7]} + {23'b0, up};
    // A carry out of the fraction leaves sum[22:0] all zero, so only the exponent moves.
    assign packed_o = zero ? 32'h0 : {1'b0, exp + {7'b0, sum[23]}, sum[22:0]};
endmodule

// File: rtl/fixed_to_float.sv
// fixed_to_float: iterative Q8.23 unsigned fixed-point to IEEE-754 single converter.
module fixed_to_float
    import fisr_pkg::*;
#(
    parameter int IN_W   = 31,
    parameter int F_BITS = FRAC_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] fixed_in,
    output logic            ready_out,
    output logic [31:0]     float_out,
    output logic            busy
);
    localparam logic [7:0] EXP_TOP = 8'(FLOAT_BIAS + IN_W - 1 - F_BITS);
    f2x_state_t      state_q, state_d;
    logic [IN_W-1:0] mant_q, mant_d;
    logic [4:0]      lz_q, lz_d;
    logic            zero_q, zero_d, ready_q, ready_d;
    logic [31:0]     res_q, res_d, float_q, float_d, pk;
    rne_round_pack u_rp (
        .mant     (mant_q[29:0]),
        .exp      (EXP_TOP - {3'b0, lz_q}),
        .zero     (zero_q),
        .packed_o (pk)
    );
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        lz_d    = lz_q;
        zero_d  = zero_q;
        res_d   = res_q;
        float_d = float_q;
        ready_d = 1'b0;
        case (state_q)
            F2X_IDLE: if (start) begin
                mant_d  = fixed_in;
                lz_d    = '0;
                zero_d  = 1'b0;
                state_d = F2X_NORM;
            end
            F2X_NORM: if (mant_q == '0) begin
                zero_d  = 1'b1;
                state_d = F2X_PACK;
            end else if (mant_q[IN_W-1]) begin
                state_d = F2X_ROUND;
            end else begin
                mant_d = mant_q << 1;
                lz_d   = lz_q + 5'd1;
            end
            F2X_ROUND: begin
                res_d   = pk;
                state_d = F2X_PACK;
            end
            F2X_PACK: begin
                float_d = zero_q ? 32'h0 : res_q;
                ready_d = 1'b1;
                state_d = F2X_IDLE;
            end
            default: state_d = F2X_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F2X_IDLE;
            mant_q  <= '0;
            lz_q    <= '0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            float_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            lz_q    <= lz_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            float_q <= float_d;
            ready_q <= ready_d;
        end
    end
    assign ready_out = ready_q;
    assign float_out = float_q;
    assign busy      = state_q != F2X_IDLE;
endmodule
